// File: rtl/fft4_input_stage_pkg.sv
// Shared types, constants and the saturating clamp for the 4-point FFT input stage.
// The butterfly datapath width is fixed here; DATA_W overrides elsewhere must match FFT_DATA_W.
package fft4_input_stage_pkg;

    localparam int FFT_DATA_W = 8;
    localparam int FFT_N      = 4;
    localparam int IDX_W      = 2;

    typedef struct packed {
        logic [FFT_DATA_W-1:0] val;
        logic                  sat;
    } sat_res_t;

    // Clamp an exact (DATA_W+1)-bit signed result into DATA_W bits; overflow shows as differing top bits.
    function automatic sat_res_t sat_clamp(input logic [FFT_DATA_W:0] v);
        sat_res_t r;
        r.sat = v[FFT_DATA_W] ^ v[FFT_DATA_W-1];
        if (r.sat) begin
            if (v[FFT_DATA_W]) begin
                r.val = {1'b1, {(FFT_DATA_W-1){1'b0}}};
            end else begin
                r.val = {1'b0, {(FFT_DATA_W-1){1'b1}}};
            end
        end else begin
            r.val = v[FFT_DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft4_input_stage_if.sv
// Sample intake and frame output stream of the FFT input stage.
interface fft4_input_stage_if #(
    parameter int DATA_W = fft4_input_stage_pkg::FFT_DATA_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_first;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_e0;
    logic [DATA_W-1:0] out_e1;
    logic [DATA_W-1:0] out_o0;
    logic [DATA_W-1:0] out_o1;
    logic              out_sat;
    logic              frame_err;

    modport master (
        output in_valid, in_data, in_first, out_ready,
        input  in_ready, out_valid, out_e0, out_e1, out_o0, out_o1, out_sat, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_first, out_ready,
        output in_ready, out_valid, out_e0, out_e1, out_o0, out_o1, out_sat, frame_err
    );

endinterface

// File: rtl/fft4_input_stage_bfly2.sv
// Radix-2 butterfly: saturated a+b and a-b with per-result clamp flags.
module fft4_input_stage_bfly2
    import fft4_input_stage_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic [DATA_W-1:0] diff,
    output logic              sat_sum,
    output logic              sat_diff
);

    logic [DATA_W:0] a_ext_s;
    logic [DATA_W:0] b_ext_s;
    logic [DATA_W:0] sum_ext_s;
    logic [DATA_W:0] diff_ext_s;
    sat_res_t        sum_res_s;
    sat_res_t        diff_res_s;

    // Exact one-bit-wider arithmetic, then clamp back to DATA_W.
    always_comb begin
        a_ext_s    = {a[DATA_W-1], a};
        b_ext_s    = {b[DATA_W-1], b};
        sum_ext_s  = a_ext_s + b_ext_s;
        diff_ext_s = a_ext_s - b_ext_s;
        sum_res_s  = sat_clamp(sum_ext_s);
        diff_res_s = sat_clamp(diff_ext_s);
        sum        = sum_res_s.val;
        diff       = diff_res_s.val;
        sat_sum    = sum_res_s.sat;
        sat_diff   = diff_res_s.sat;
    end

endmodule

// File: rtl/fft4_input_stage.sv
// First radix-2 stage of the 4-point FFT: serial sample intake, stage-1 butterflies,
// registered output frame with one frame of skid buffering held in the sample buffer.
module fft4_input_stage
    import fft4_input_stage_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    fft4_input_stage_if.slave bus
);

    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] x_r [0:FFT_N-1];
    logic              buf_full_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] e0_r;
    logic [DATA_W-1:0] e1_r;
    logic [DATA_W-1:0] o0_r;
    logic [DATA_W-1:0] o1_r;
    logic              out_sat_r;
    logic              frame_err_r;

    logic              accept_s;
    logic              out_free_s;
    logic              resync_s;
    logic              stray_s;
    logic              complete_s;
    logic              load_direct_s;
    logic              load_buf_s;
    logic [DATA_W-1:0] x3_sel_s;
    logic [DATA_W-1:0] e0_s;
    logic [DATA_W-1:0] e1_s;
    logic [DATA_W-1:0] o0_s;
    logic [DATA_W-1:0] o1_s;
    logic              sat_e0_s;
    logic              sat_e1_s;
    logic              sat_o0_s;
    logic              sat_o1_s;

    // Handshake decode; x3 comes from the live sample on a direct load, else from the buffered frame.
    always_comb begin
        accept_s      = bus.in_valid & ~buf_full_r;
        out_free_s    = ~out_valid_r | bus.out_ready;
        resync_s      = accept_s & bus.in_first & (idx_r != 2'd0);
        stray_s       = accept_s & ~bus.in_first & (idx_r == 2'd0);
        complete_s    = accept_s & ~bus.in_first & (idx_r == 2'd3);
        load_direct_s = complete_s & out_free_s;
        load_buf_s    = buf_full_r & out_valid_r & bus.out_ready;
        if (load_direct_s) begin
            x3_sel_s = bus.in_data;
        end else begin
            x3_sel_s = x_r[3];
        end
    end

    fft4_input_stage_bfly2 #(.DATA_W(DATA_W)) u_bfly_even (
        .a        (x_r[0]),
        .b        (x_r[2]),
        .sum      (e0_s),
        .diff     (e1_s),
        .sat_sum  (sat_e0_s),
        .sat_diff (sat_e1_s)
    );

    fft4_input_stage_bfly2 #(.DATA_W(DATA_W)) u_bfly_odd (
        .a        (x_r[1]),
        .b        (x3_sel_s),
        .sum      (o0_s),
        .diff     (o1_s),
        .sat_sum  (sat_o0_s),
        .sat_diff (sat_o1_s)
    );

    // Sample buffer and position counter; in_first always restarts the frame at x0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= 2'd0;
            for (int i = 0; i < FFT_N; i++) begin
                x_r[i] <= {DATA_W{1'b0}};
            end
        end else if (accept_s) begin
            if (bus.in_first) begin
                x_r[0] <= bus.in_data;
                idx_r  <= 2'd1;
            end else if (idx_r == 2'd0) begin
                idx_r <= 2'd0;
            end else begin
                x_r[idx_r] <= bus.in_data;
                idx_r      <= idx_r + 2'd1;
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    // Skid flag: a completed frame that cannot reach the output regs parks in the sample buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full_r <= 1'b0;
        end else if (complete_s && !out_free_s) begin
            buf_full_r <= 1'b1;
        end else if (load_buf_s) begin
            buf_full_r <= 1'b0;
        end else begin
            buf_full_r <= buf_full_r;
        end
    end

    // Output register bank; values hold while a frame waits for out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            e0_r        <= {DATA_W{1'b0}};
            e1_r        <= {DATA_W{1'b0}};
            o0_r        <= {DATA_W{1'b0}};
            o1_r        <= {DATA_W{1'b0}};
            out_sat_r   <= 1'b0;
        end else if (load_direct_s || load_buf_s) begin
            out_valid_r <= 1'b1;
            e0_r        <= e0_s;
            e1_r        <= e1_s;
            o0_r        <= o0_s;
            o1_r        <= o1_s;
            out_sat_r   <= sat_e0_s | sat_e1_s | sat_o0_s | sat_o1_s;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // One-cycle pulse whenever intake discards data to regain frame alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= resync_s | stray_s;
        end
    end

    assign bus.in_ready  = ~buf_full_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_e0    = e0_r;
    assign bus.out_e1    = e1_r;
    assign bus.out_o0    = o0_r;
    assign bus.out_o1    = o1_r;
    assign bus.out_sat   = out_sat_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_fft4_input_stage.sv
// Scoreboard bench for fft4_input_stage: directed frames push hand-computed results, a negedge monitor checks them.
module tb_fft4_input_stage;
    import fft4_input_stage_pkg::*;

    localparam int W = FFT_DATA_W;

    typedef struct {
        int e0;
        int e1;
        int o0;
        int o1;
        int sat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    exp_t exp_q[$];
    int   vld_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   err_cnt  = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    fft4_input_stage_if #(.DATA_W(W)) bus ();

    fft4_input_stage #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    // Monitor: compare the presented frame against the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (bus.frame_err) err_cnt++;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("out_e0", sx(bus.out_e0), e.e0);
                    chk("out_e1", sx(bus.out_e1), e.e1);
                    chk("out_o0", sx(bus.out_o0), e.o0);
                    chk("out_o1", sx(bus.out_o1), e.o1);
                    chk("out_sat", int'(bus.out_sat), e.sat);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        vld_q.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic f);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d[W-1:0];
        bus.in_first = f;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 0, 1);
        step();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic frame(input int a, input int b, input int c, input int d,
                         input int e0, input int e1, input int o0, input int o1, input int sat);
        exp_t e;
        e.e0 = e0; e.e1 = e1; e.o0 = o0; e.o1 = o1; e.sat = sat;
        exp_q.push_back(e);
        send(a, 1'b1);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
        chk({tag, "_out_e0"}, sx(bus.out_e0), 0);
        chk({tag, "_out_e1"}, sx(bus.out_e1), 0);
        chk({tag, "_out_o0"}, sx(bus.out_o0), 0);
        chk({tag, "_out_o1"}, sx(bus.out_o1), 0);
        chk({tag, "_out_sat"}, int'(bus.out_sat), 0);
        chk({tag, "_frame_err"}, int'(bus.frame_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        idle();
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        chk_reset("reset");
        rst_n = 1'b1;
        step();

        // Basic frame, single-cycle out_valid
        bus.out_ready = 1'b1;
        frame(10, 20, 30, 40, 40, -20, 60, -20, 0);
        idle();
        drain("t1_drain");

        // Saturation both directions
        frame(100, -100, 100, -100, 127, 0, -128, 0, 1);
        frame(-128, 0, -128, 0, -128, 0, 0, 0, 1);
        idle();
        drain("t2_drain");

        // Backpressure: A held, B parks in the buffer
        bus.out_ready = 1'b0;
        frame(1, 2, 3, 4, 4, -2, 6, -2, 0);
        frame(5, 6, 7, 8, 12, -2, 14, -2, 0);
        chk("t3_in_ready_stalled", int'(bus.in_ready), 0);
        idle();
        step();
        step();
        step();
        chk("t3_in_ready_still_stalled", int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        drain("t3_drain");
        step();
        chk("t3_in_ready_after", int'(bus.in_ready), 1);

        // Resync on early in_first
        e = err_cnt;
        begin
            exp_t x;
            x.e0 = 16; x.e1 = 2; x.o0 = 14; x.o1 = 2; x.sat = 0;
            exp_q.push_back(x);
        end
        send(1, 1'b1);
        send(2, 1'b0);
        send(9, 1'b1);
        send(8, 1'b0);
        send(7, 1'b0);
        send(6, 1'b0);
        idle();
        drain("t4_drain");
        step();
        chk("t4_resync_err", err_cnt - e, 1);

        // Stray sample without in_first is dropped
        e = err_cnt;
        send(5, 1'b0);
        idle();
        step();
        step();
        chk("t4_stray_err", err_cnt - e, 1);
        frame(10, 20, 30, 40, 40, -20, 60, -20, 0);
        idle();
        drain("t4_post_stray_drain");
        chk("t4_no_extra_err", err_cnt - e, 1);

        // Continuous stream of three frames
        vld_q.delete();
        frame(1, 2, 3, 4, 4, -2, 6, -2, 0);
        frame(-5, 7, 2, -3, -3, -7, 4, 10, 0);
        frame(50, 60, 70, 80, 120, -20, 127, -20, 1);
        idle();
        drain("t5_drain");
        chk("t5_frames", vld_q.size(), 3);
        if (vld_q.size() == 3) begin
            for (int i = 1; i < 3; i++) begin
                chk("t5_spacing", vld_q[i] - vld_q[i-1], 4);
            end
        end

        // Reset mid-frame
        e = err_cnt;
        send(1, 1'b1);
        send(2, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        chk_reset("t6a_reset");
        step();
        rst_n = 1'b1;
        step();
        frame(10, 20, 30, 40, 40, -20, 60, -20, 0);
        idle();
        drain("t6a_drain");
        step();
        chk("t6a_no_err", err_cnt - e, 0);

        // Reset during buffer-full stall
        bus.out_ready = 1'b0;
        frame(1, 2, 3, 4, 4, -2, 6, -2, 0);
        frame(5, 6, 7, 8, 12, -2, 14, -2, 0);
        chk("t6b_in_ready_stalled", int'(bus.in_ready), 0);
        idle();
        rst_n = 1'b0;
        #1;
        chk_reset("t6b_reset");
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        frame(-5, 7, 2, -3, -3, -7, 4, 10, 0);
        idle();
        drain("t6b_drain");
        step();
        chk("t6b_in_ready_after", int'(bus.in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
